// File: rtl/vga_sync_decoder.sv
// Recovers pixel column, line, active-video and timing lock from raw active-low VGA sync pins.
// Define VGA_DEC_MEASURE_EN to add the measured line_period/frame_lines outputs.
//   state  | meaning
//   SEARCH | hunting for GOOD_LINES consecutive correct line periods
//   HLOCK  | line timing confirmed, waiting for the first vsync fall
//   VMEAS  | counting lines of one full frame
//   LOCKED | line and frame timing confirmed, de enabled
module vga_sync_decoder #(
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_TOTAL      = 800,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_TOTAL      = 525,
    parameter int GOOD_LINES   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        de,
    output logic        locked,
    output logic        err
`ifdef VGA_DEC_MEASURE_EN
    ,
    output logic [10:0] line_period,
    output logic [9:0]  frame_lines
`endif
);

    typedef enum logic [1:0] {SEARCH, HLOCK, VMEAS, LOCKED} state_t;

    localparam logic [9:0]  X_LOAD   = 10'(H_SYNC_START + 1);
    localparam logic [9:0]  X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  X_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]  Y_LOAD   = 10'(V_SYNC_START);
    localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  Y_ACT    = 10'(V_ACTIVE);
    localparam logic [10:0] LP_MAX   = 11'h7ff;
    localparam logic [10:0] LP_TOTAL = 11'(H_TOTAL);
    localparam logic [10:0] LP_LIMIT = 11'(2 * H_TOTAL);
    localparam logic [9:0]  FL_MAX   = 10'h3ff;
    localparam logic [9:0]  FL_TOTAL = 10'(V_TOTAL);
    localparam logic [3:0]  RUN_LAST = 4'(GOOD_LINES - 1);

    state_t      state_q, state_d;
    logic        s_hs_q, s_hs_d, p_hs_q, p_hs_d;
    logic        s_vs_q, s_vs_d, p_vs_q, p_vs_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic        de_q, de_d, locked_q, locked_d, err_q, err_d;
    logic [10:0] lp_q, lp_d, period;
    logic [9:0]  fl_q, fl_d;
    logic [3:0]  run_q, run_d;
    logic        hfall, vfall, x_wrap, period_ok, timeout, line_bad, frame_bad, fail;

    always_comb begin
        s_hs_d = hsync_in;
        p_hs_d = s_hs_q;
        s_vs_d = vsync_in;
        p_vs_d = s_vs_q;
        hfall  = p_hs_q & ~s_hs_q;
        vfall  = p_vs_q & ~s_vs_q;
        x_wrap = (x_q == X_LAST) & ~hfall;

        if (hfall)       x_d = X_LOAD;
        else if (x_wrap) x_d = '0;
        else             x_d = x_q + 10'd1;

        y_d = y_q;
        if (vfall)       y_d = Y_LOAD;
        else if (x_wrap) y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;

        // period doubles as the saturating increment of the line counter
        period    = (lp_q == LP_MAX) ? LP_MAX : lp_q + 11'd1;
        period_ok = (period == LP_TOTAL);
        lp_d      = hfall ? '0 : period;
        timeout   = ~hfall & (lp_q == LP_LIMIT);
        line_bad  = (hfall & ~period_ok) | timeout;
        frame_bad = vfall & (fl_q != FL_TOTAL);

        if (vfall)                        fl_d = {9'd0, hfall};
        else if (hfall && fl_q != FL_MAX) fl_d = fl_q + 10'd1;
        else                              fl_d = fl_q;
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        err_d   = 1'b0;
        fail    = ((state_q == HLOCK) & line_bad) |
                  (((state_q == VMEAS) | (state_q == LOCKED)) & (line_bad | frame_bad));
        if (fail) begin
            state_d = SEARCH;
            run_d   = '0;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (hfall) begin
                        if (!period_ok) begin
                            run_d = '0;
                        end else if (run_q == RUN_LAST) begin
                            state_d = HLOCK;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + 4'd1;
                        end
                    end
                end
                HLOCK:   if (vfall) state_d = VMEAS;
                VMEAS:   if (vfall) state_d = LOCKED;
                LOCKED:  state_d = LOCKED;
                default: state_d = SEARCH;
            endcase
        end
        locked_d = (state_d == LOCKED);
        de_d     = locked_d & (x_d < X_ACT) & (y_d < Y_ACT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_hs_q   <= 1'b1;
            p_hs_q   <= 1'b1;
            s_vs_q   <= 1'b1;
            p_vs_q   <= 1'b1;
            x_q      <= '0;
            y_q      <= '0;
            de_q     <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            lp_q     <= '0;
            fl_q     <= '0;
            run_q    <= '0;
            state_q  <= SEARCH;
        end else begin
            s_hs_q   <= s_hs_d;
            p_hs_q   <= p_hs_d;
            s_vs_q   <= s_vs_d;
            p_vs_q   <= p_vs_d;
            x_q      <= x_d;
            y_q      <= y_d;
            de_q     <= de_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            lp_q     <= lp_d;
            fl_q     <= fl_d;
            run_q    <= run_d;
            state_q  <= state_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign de     = de_q;
    assign locked = locked_q;
    assign err    = err_q;

`ifdef VGA_DEC_MEASURE_EN
    logic [10:0] line_period_q, line_period_d;
    logic [9:0]  frame_lines_q, frame_lines_d;

    always_comb begin
        line_period_d = hfall ? period : line_period_q;
        frame_lines_d = vfall ? fl_q : frame_lines_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_period_q <= '0;
            frame_lines_q <= '0;
        end else begin
            line_period_q <= line_period_d;
            frame_lines_q <= frame_lines_d;
        end
    end

    assign line_period = line_period_q;
    assign frame_lines = frame_lines_q;
`endif

endmodule
